// File: rtl/ex_stage_unit_pkg.sv
// Shared encodings for the execute stage: ALUOp classes, R-type funct codes,
// forward-select values, internal ALU control and squash FSM states.
package ex_stage_unit_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_ZERO
    } alu_ctrl_e;

    typedef enum logic {
        SQ_NORMAL,
        SQ_SQUASH
    } squash_state_e;

    function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
        alu_ctrl_e ctrl;
        ctrl = ALU_ZERO;
        case (alu_op)
            ALUOP_ADD: ctrl = ALU_ADD;
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ctrl = ALU_ADD;
                    FUNCT_SUB: ctrl = ALU_SUB;
                    FUNCT_AND: ctrl = ALU_AND;
                    FUNCT_OR:  ctrl = ALU_OR;
                    FUNCT_SLT: ctrl = ALU_SLT;
                    default:   ctrl = ALU_ZERO;
                endcase
            end
            default: ctrl = ALU_ZERO;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/ex_stage_unit_if.sv
// ID/EX pipeline register bundle: driven by the decode stage, consumed by EX.
interface ex_stage_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] ID_EX_pc_incr;
    logic [DATA_W-1:0] ID_EX_reg_RD1;
    logic [DATA_W-1:0] ID_EX_reg_RD2;
    logic [DATA_W-1:0] ID_EX_reg_extend_immed;
    logic [4:0]        ID_EX_reg_rt;
    logic [4:0]        ID_EX_reg_rd;
    logic              ID_EX_reg_RegDst;
    logic              ID_EX_reg_ALUSrc;
    logic              ID_EX_reg_MemtoReg;
    logic              ID_EX_reg_RegWrite;
    logic              ID_EX_reg_MemRead;
    logic              ID_EX_reg_MemWrite;
    logic              ID_EX_reg_Branch;
    logic              ID_EX_reg_Jump;
    logic [1:0]        ID_EX_reg_ALUOp;
    logic [DATA_W-1:0] ID_EX_jump_target;

    modport master (
        output ID_EX_pc_incr, ID_EX_reg_RD1, ID_EX_reg_RD2, ID_EX_reg_extend_immed,
               ID_EX_reg_rt, ID_EX_reg_rd, ID_EX_reg_RegDst, ID_EX_reg_ALUSrc,
               ID_EX_reg_MemtoReg, ID_EX_reg_RegWrite, ID_EX_reg_MemRead,
               ID_EX_reg_MemWrite, ID_EX_reg_Branch, ID_EX_reg_Jump,
               ID_EX_reg_ALUOp, ID_EX_jump_target
    );

    modport slave (
        input ID_EX_pc_incr, ID_EX_reg_RD1, ID_EX_reg_RD2, ID_EX_reg_extend_immed,
              ID_EX_reg_rt, ID_EX_reg_rd, ID_EX_reg_RegDst, ID_EX_reg_ALUSrc,
              ID_EX_reg_MemtoReg, ID_EX_reg_RegWrite, ID_EX_reg_MemRead,
              ID_EX_reg_MemWrite, ID_EX_reg_Branch, ID_EX_reg_Jump,
              ID_EX_reg_ALUOp, ID_EX_jump_target
    );
endinterface

// File: rtl/ex_stage_unit_alu_core.sv
// Combinational ALU: add/sub/and/or/signed slt, zero for unsupported operations.
module alu_core
    import ex_stage_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  alu_ctrl_e         alu_ctrl,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage_unit.sv
// Execute stage: forwarding, ALU, beq/jump redirect, EX/MEM register and the
// squash FSM that nullifies wrong-path slots after a redirect.
module ex_stage_unit
    import ex_stage_unit_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned SQUASH_SLOTS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    ex_stage_unit_if.slave    id_ex,
    input  logic [1:0]        fwd_a_sel,
    input  logic [1:0]        fwd_b_sel,
    input  logic [DATA_W-1:0] ex_mem_fwd_data,
    input  logic [DATA_W-1:0] mem_wb_fwd_data,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] redirect_target,
    output logic [DATA_W-1:0] EX_MEM_alu_result,
    output logic [DATA_W-1:0] EX_MEM_write_data,
    output logic [4:0]        EX_MEM_write_reg,
    output logic              EX_MEM_RegWrite,
    output logic              EX_MEM_MemRead,
    output logic              EX_MEM_MemWrite,
    output logic              EX_MEM_MemtoReg,
    output logic              squash_active
);

    localparam int unsigned CNT_W = $clog2(SQUASH_SLOTS + 1);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_bf;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] branch_target;
    logic              branch_taken;
    alu_ctrl_e         alu_ctrl;
    squash_state_e     sq_state;
    logic [CNT_W-1:0]  squash_cnt;

    always_comb begin
        op_a = id_ex.ID_EX_reg_RD1;
        case (fwd_a_sel)
            FWD_MEM_WB: op_a = mem_wb_fwd_data;
            FWD_EX_MEM: op_a = ex_mem_fwd_data;
            default:    op_a = id_ex.ID_EX_reg_RD1;
        endcase
        op_bf = id_ex.ID_EX_reg_RD2;
        case (fwd_b_sel)
            FWD_MEM_WB: op_bf = mem_wb_fwd_data;
            FWD_EX_MEM: op_bf = ex_mem_fwd_data;
            default:    op_bf = id_ex.ID_EX_reg_RD2;
        endcase
    end

    assign op_b     = id_ex.ID_EX_reg_ALUSrc ? id_ex.ID_EX_reg_extend_immed : op_bf;
    assign alu_ctrl = alu_decode(id_ex.ID_EX_reg_ALUOp, id_ex.ID_EX_reg_extend_immed[5:0]);

    alu_core #(.DATA_W(DATA_W)) u_alu_core (
        .alu_ctrl (alu_ctrl),
        .a        (op_a),
        .b        (op_b),
        .result   (alu_result)
    );

    // Branch compare uses the forwarded operands, never the immediate-muxed B.
    assign branch_taken    = id_ex.ID_EX_reg_Branch && (op_a == op_bf);
    assign branch_target   = id_ex.ID_EX_pc_incr + {id_ex.ID_EX_reg_extend_immed[DATA_W-3:0], 2'b00};
    assign squash_active   = (sq_state != SQ_NORMAL);
    assign pc_redirect     = rst_n && !squash_active && !stall &&
                             (id_ex.ID_EX_reg_Jump || branch_taken);
    assign redirect_target = id_ex.ID_EX_reg_Jump ? id_ex.ID_EX_jump_target : branch_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EX_MEM_alu_result <= '0;
            EX_MEM_write_data <= '0;
            EX_MEM_write_reg  <= '0;
            EX_MEM_RegWrite   <= 1'b0;
            EX_MEM_MemRead    <= 1'b0;
            EX_MEM_MemWrite   <= 1'b0;
            EX_MEM_MemtoReg   <= 1'b0;
            sq_state          <= SQ_NORMAL;
            squash_cnt        <= '0;
        end else if (!stall) begin
            EX_MEM_alu_result <= alu_result;
            EX_MEM_write_data <= op_bf;
            EX_MEM_write_reg  <= id_ex.ID_EX_reg_RegDst ? id_ex.ID_EX_reg_rd : id_ex.ID_EX_reg_rt;
            EX_MEM_RegWrite   <= id_ex.ID_EX_reg_RegWrite && !squash_active;
            EX_MEM_MemRead    <= id_ex.ID_EX_reg_MemRead  && !squash_active;
            EX_MEM_MemWrite   <= id_ex.ID_EX_reg_MemWrite && !squash_active;
            EX_MEM_MemtoReg   <= id_ex.ID_EX_reg_MemtoReg && !squash_active;
            case (sq_state)
                SQ_NORMAL: begin
                    if (pc_redirect) begin
                        sq_state   <= SQ_SQUASH;
                        squash_cnt <= CNT_W'(SQUASH_SLOTS);
                    end
                end
                SQ_SQUASH: begin
                    if (squash_cnt == CNT_W'(1)) begin
                        sq_state   <= SQ_NORMAL;
                        squash_cnt <= '0;
                    end else begin
                        squash_cnt <= squash_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    sq_state   <= SQ_NORMAL;
                    squash_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage_unit.sv
// Self-checking bench for ex_stage_unit: directed scenarios plus random traffic
// compared against a behavioural model of the execute stage.
module tb_ex_stage_unit;

    localparam int SLOTS = 2;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] ex_mem_fwd_data, mem_wb_fwd_data;
    logic        pc_redirect;
    logic [31:0] redirect_target;
    logic [31:0] EX_MEM_alu_result, EX_MEM_write_data;
    logic [4:0]  EX_MEM_write_reg;
    logic        EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemtoReg;
    logic        squash_active;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    int          m_left;
    logic [31:0] m_alu, m_wd;
    logic [4:0]  m_wr;
    logic        m_rw, m_mr, m_mw, m_m2r;

    ex_stage_unit_if #(.DATA_W(32)) id_ex ();

    ex_stage_unit #(.DATA_W(32), .SQUASH_SLOTS(SLOTS)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .id_ex             (id_ex),
        .fwd_a_sel         (fwd_a_sel),
        .fwd_b_sel         (fwd_b_sel),
        .ex_mem_fwd_data   (ex_mem_fwd_data),
        .mem_wb_fwd_data   (mem_wb_fwd_data),
        .pc_redirect       (pc_redirect),
        .redirect_target   (redirect_target),
        .EX_MEM_alu_result (EX_MEM_alu_result),
        .EX_MEM_write_data (EX_MEM_write_data),
        .EX_MEM_write_reg  (EX_MEM_write_reg),
        .EX_MEM_RegWrite   (EX_MEM_RegWrite),
        .EX_MEM_MemRead    (EX_MEM_MemRead),
        .EX_MEM_MemWrite   (EX_MEM_MemWrite),
        .EX_MEM_MemtoReg   (EX_MEM_MemtoReg),
        .squash_active     (squash_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'b01) return mem_wb_fwd_data;
        if (sel == 2'b10) return ex_mem_fwd_data;
        return rf;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [5:0] funct,
                                            input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b10) begin
            if (funct == 6'h20) return a + b;
            if (funct == 6'h22) return a - b;
            if (funct == 6'h24) return a & b;
            if (funct == 6'h25) return a | b;
            if (funct == 6'h2A) return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        end
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_left = 0;
        m_alu = '0; m_wd = '0; m_wr = '0;
        m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
    endtask

    task automatic check_regs(input string pfx);
        check({pfx, "_alu_result"}, EX_MEM_alu_result, m_alu);
        check({pfx, "_write_data"}, EX_MEM_write_data, m_wd);
        check({pfx, "_write_reg"},  {27'd0, EX_MEM_write_reg}, {27'd0, m_wr});
        check({pfx, "_RegWrite"},   {31'd0, EX_MEM_RegWrite}, {31'd0, m_rw});
        check({pfx, "_MemRead"},    {31'd0, EX_MEM_MemRead},  {31'd0, m_mr});
        check({pfx, "_MemWrite"},   {31'd0, EX_MEM_MemWrite}, {31'd0, m_mw});
        check({pfx, "_MemtoReg"},   {31'd0, EX_MEM_MemtoReg}, {31'd0, m_m2r});
    endtask

    // One clock: check combinational outputs, advance the model, check the EX/MEM register.
    task automatic tick();
        logic [31:0] a, bf, b, tgt;
        logic        sq, redir;
        #1;
        a   = fwd(fwd_a_sel, id_ex.ID_EX_reg_RD1);
        bf  = fwd(fwd_b_sel, id_ex.ID_EX_reg_RD2);
        b   = id_ex.ID_EX_reg_ALUSrc ? id_ex.ID_EX_reg_extend_immed : bf;
        sq  = (m_left != 0);
        redir = !sq && !stall && (id_ex.ID_EX_reg_Jump || (id_ex.ID_EX_reg_Branch && a == bf));
        tgt = id_ex.ID_EX_reg_Jump ? id_ex.ID_EX_jump_target
                                   : id_ex.ID_EX_pc_incr + (id_ex.ID_EX_reg_extend_immed << 2);
        check("squash_active", {31'd0, squash_active}, {31'd0, sq});
        check("pc_redirect", {31'd0, pc_redirect}, {31'd0, redir});
        if (redir) check("redirect_target", redirect_target, tgt);
        if (!stall) begin
            m_alu = alu_ref(id_ex.ID_EX_reg_ALUOp, id_ex.ID_EX_reg_extend_immed[5:0], a, b);
            m_wd  = bf;
            m_wr  = id_ex.ID_EX_reg_RegDst ? id_ex.ID_EX_reg_rd : id_ex.ID_EX_reg_rt;
            m_rw  = id_ex.ID_EX_reg_RegWrite && !sq;
            m_mr  = id_ex.ID_EX_reg_MemRead  && !sq;
            m_mw  = id_ex.ID_EX_reg_MemWrite && !sq;
            m_m2r = id_ex.ID_EX_reg_MemtoReg && !sq;
            if (sq) m_left = m_left - 1;
            else if (redir) m_left = SLOTS;
        end
        @(posedge clk);
        #1;
        check_regs("ex_mem");
    endtask

    task automatic clear_inputs();
        id_ex.ID_EX_pc_incr = '0;          id_ex.ID_EX_reg_RD1 = '0;
        id_ex.ID_EX_reg_RD2 = '0;          id_ex.ID_EX_reg_extend_immed = '0;
        id_ex.ID_EX_reg_rt = '0;           id_ex.ID_EX_reg_rd = '0;
        id_ex.ID_EX_reg_RegDst = 0;        id_ex.ID_EX_reg_ALUSrc = 0;
        id_ex.ID_EX_reg_MemtoReg = 0;      id_ex.ID_EX_reg_RegWrite = 0;
        id_ex.ID_EX_reg_MemRead = 0;       id_ex.ID_EX_reg_MemWrite = 0;
        id_ex.ID_EX_reg_Branch = 0;        id_ex.ID_EX_reg_Jump = 0;
        id_ex.ID_EX_reg_ALUOp = '0;        id_ex.ID_EX_jump_target = '0;
        fwd_a_sel = '0; fwd_b_sel = '0;
        ex_mem_fwd_data = '0; mem_wb_fwd_data = '0;
    endtask

    task automatic rand_inputs();
        logic [5:0]  functs [6];
        logic [31:0] r, v;
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
        r = $urandom;
        id_ex.ID_EX_pc_incr          = $urandom & 32'hFFFF_FFFC;
        id_ex.ID_EX_reg_RD1          = $urandom;
        id_ex.ID_EX_reg_RD2          = $urandom;
        id_ex.ID_EX_reg_extend_immed = {r[31:6], functs[$urandom_range(0, 5)]};
        id_ex.ID_EX_reg_rt           = 5'($urandom);
        id_ex.ID_EX_reg_rd           = 5'($urandom);
        id_ex.ID_EX_reg_RegDst       = 1'($urandom_range(0, 1));
        id_ex.ID_EX_reg_ALUSrc       = 1'($urandom_range(0, 1));
        id_ex.ID_EX_reg_MemtoReg     = 1'($urandom_range(0, 1));
        id_ex.ID_EX_reg_RegWrite     = 1'($urandom_range(0, 1));
        id_ex.ID_EX_reg_MemRead      = 1'($urandom_range(0, 1));
        id_ex.ID_EX_reg_MemWrite     = 1'($urandom_range(0, 1));
        id_ex.ID_EX_reg_Branch       = ($urandom_range(0, 3) == 0);
        id_ex.ID_EX_reg_Jump         = ($urandom_range(0, 7) == 0);
        id_ex.ID_EX_reg_ALUOp        = 2'($urandom_range(0, 3));
        id_ex.ID_EX_jump_target      = $urandom;
        fwd_a_sel       = 2'($urandom_range(0, 3));
        fwd_b_sel       = 2'($urandom_range(0, 3));
        ex_mem_fwd_data = $urandom;
        mem_wb_fwd_data = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            v = $urandom;
            id_ex.ID_EX_reg_RD1 = v; id_ex.ID_EX_reg_RD2 = v;
            ex_mem_fwd_data = v;     mem_wb_fwd_data = v;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        clear_inputs();
        model_reset();

        // Reset held for three cycles with random inputs
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            stall = 1'($urandom_range(0, 1));
            #1;
            check_regs("reset");
            check("reset_pc_redirect", {31'd0, pc_redirect}, 32'd0);
            check("reset_squash", {31'd0, squash_active}, 32'd0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        stall = 1'b0;
        clear_inputs();

        // R-type sub with EX/MEM forwarding on A: 100 - 30
        id_ex.ID_EX_reg_ALUOp = 2'b10;
        id_ex.ID_EX_reg_extend_immed = 32'h22;
        id_ex.ID_EX_reg_RD1 = 32'd5;
        fwd_a_sel = 2'b10;
        ex_mem_fwd_data = 32'd100;
        id_ex.ID_EX_reg_RD2 = 32'd30;
        id_ex.ID_EX_reg_RegDst = 1'b1;
        id_ex.ID_EX_reg_rd = 5'd9;
        id_ex.ID_EX_reg_rt = 5'd3;
        id_ex.ID_EX_reg_RegWrite = 1'b1;
        tick();
        check("rtype_alu", EX_MEM_alu_result, 32'd70);
        check("rtype_wreg", {27'd0, EX_MEM_write_reg}, 32'd9);
        check("rtype_regwrite", {31'd0, EX_MEM_RegWrite}, 32'd1);

        // Taken beq, then a store and an add in the squashed slots
        clear_inputs();
        id_ex.ID_EX_reg_ALUOp = 2'b01;
        id_ex.ID_EX_reg_Branch = 1'b1;
        id_ex.ID_EX_pc_incr = 32'h40;
        id_ex.ID_EX_reg_extend_immed = 32'hFFFF_FFFE;
        id_ex.ID_EX_reg_RD1 = 32'd7;
        id_ex.ID_EX_reg_RD2 = 32'd7;
        #1;
        check("beq_redirect", {31'd0, pc_redirect}, 32'd1);
        check("beq_target", redirect_target, 32'h38);
        tick();
        clear_inputs();
        id_ex.ID_EX_reg_MemWrite = 1'b1;
        #1;
        check("beq_squash1", {31'd0, squash_active}, 32'd1);
        tick();
        check("squash_store_memwrite", {31'd0, EX_MEM_MemWrite}, 32'd0);
        clear_inputs();
        id_ex.ID_EX_reg_RegWrite = 1'b1;
        id_ex.ID_EX_reg_ALUOp = 2'b00;
        #1;
        check("beq_squash2", {31'd0, squash_active}, 32'd1);
        tick();
        check("squash_add_regwrite", {31'd0, EX_MEM_RegWrite}, 32'd0);
        check("beq_squash_done", {31'd0, squash_active}, 32'd0);

        // Jump and branch together; jump in the squashed slot must not redirect
        clear_inputs();
        id_ex.ID_EX_reg_Jump = 1'b1;
        id_ex.ID_EX_reg_Branch = 1'b1;
        id_ex.ID_EX_jump_target = 32'h1000;
        id_ex.ID_EX_pc_incr = 32'h80;
        #1;
        check("jump_prio_target", redirect_target, 32'h1000);
        tick();
        clear_inputs();
        id_ex.ID_EX_reg_Jump = 1'b1;
        id_ex.ID_EX_jump_target = 32'h2000;
        #1;
        check("squashed_jump_no_redirect", {31'd0, pc_redirect}, 32'd0);
        tick();
        clear_inputs();
        tick();

        // Stall held three cycles during squash
        id_ex.ID_EX_reg_Jump = 1'b1;
        id_ex.ID_EX_jump_target = 32'h3000;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            tick();
            check("stall_squash_held", {31'd0, squash_active}, 32'd1);
        end
        stall = 1'b0;
        clear_inputs();
        tick();
        check("stall_post1_squash", {31'd0, squash_active}, 32'd1);
        tick();
        check("stall_post2_squash", {31'd0, squash_active}, 32'd0);

        // Signed slt: -1 < 1
        clear_inputs();
        id_ex.ID_EX_reg_ALUOp = 2'b10;
        id_ex.ID_EX_reg_extend_immed = 32'h2A;
        id_ex.ID_EX_reg_RD1 = 32'hFFFF_FFFF;
        id_ex.ID_EX_reg_RD2 = 32'd1;
        tick();
        check("slt_signed", EX_MEM_alu_result, 32'd1);

        // Reset pulsed during SQUASH(2)
        clear_inputs();
        id_ex.ID_EX_reg_Jump = 1'b1;
        id_ex.ID_EX_jump_target = 32'h4000;
        tick();
        check("pre_reset_squash", {31'd0, squash_active}, 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset_squash", {31'd0, squash_active}, 32'd0);
        check_regs("midreset");
        #1;
        rst_n = 1'b1;
        clear_inputs();
        id_ex.ID_EX_reg_Branch = 1'b1;
        id_ex.ID_EX_reg_ALUOp = 2'b01;
        id_ex.ID_EX_pc_incr = 32'h100;
        id_ex.ID_EX_reg_extend_immed = 32'h4;
        id_ex.ID_EX_reg_RD1 = 32'd11;
        id_ex.ID_EX_reg_RD2 = 32'd11;
        #1;
        check("post_reset_beq", {31'd0, pc_redirect}, 32'd1);
        check("post_reset_target", redirect_target, 32'h110);
        tick();

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            stall = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
